// File: rtl/traffic_light_unit.sv
`default_nettype none
// ============================================================================
// Module  : traffic_light_unit
// Brief   : Signal-head sequencer RED -> GREEN -> YELLOW -> RED with local
//           yellow timing, minimum-green enforcement and a DARK mode.
//           Optional macro BLINK_EN: blink yellow while DARK.
// Revision: 1.0 - initial release
// ============================================================================
module traffic_light_unit #(
    parameter int CYCLES_PER_MS = 10,
    parameter int YELLOW_MS     = 3000,
    parameter int MIN_GREEN_MS  = 5000,
    parameter int BLINK_HALF_MS = 500
) (
    input  logic CLK,
    input  logic reset_general,
    input  logic enable_general,
    input  logic change,
    input  logic set_req,
    input  logic set_value,
    output logic lamp_red,
    output logic lamp_yellow,
    output logic lamp_green,
    output logic is_red,
    output logic pending,
    output logic err_dropped
);

    localparam int                 c_PRESC_W    = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CYCLES_PER_MS - 1);
    localparam logic [15:0]        c_YELLOW     = 16'(YELLOW_MS);
    localparam logic [15:0]        c_MIN_GREEN  = 16'(MIN_GREEN_MS);
    localparam logic [15:0]        c_BLINK_LAST = 16'(BLINK_HALF_MS - 1);

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_DARK   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_change_d;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [15:0]            r_ms;
    logic [15:0]            w_ms_next;
    logic                   w_tick;
    logic                   w_chg_edge;
    logic                   w_forced;
    logic                   w_restart;
    logic                   r_pending;
    logic                   w_pending_next;
    logic                   r_err;
    logic                   w_err_next;
    logic                   w_dark_yellow;
    logic                   r_lamp_red;
    logic                   r_lamp_yellow;
    logic                   r_lamp_green;
    logic                   r_is_red;

    assign w_chg_edge = change & ~r_change_d;
    assign w_tick     = (r_presc == c_PRESC_LAST);
    // Decisions use the elapsed ms as it will stand after this edge, so a
    // dwell of N ms lasts exactly N*CYCLES_PER_MS cycles from state entry.
    assign w_ms_next  = (w_tick && (r_ms != 16'hFFFF)) ? (r_ms + 16'd1) : r_ms;

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_err_next     = r_err;
        w_forced       = 1'b0;
        if (!enable_general) begin
            w_state_next   = S_DARK;
            w_pending_next = 1'b0;
        end else if (r_state == S_DARK) begin
            w_state_next   = S_RED;
        end else if (set_req) begin
            w_state_next   = set_value ? S_GREEN : S_RED;
            w_pending_next = 1'b0;
            w_forced       = 1'b1;
        end else if (w_chg_edge) begin
            case (r_state)
                S_RED:    w_state_next = S_GREEN;
                S_GREEN: begin
                    if (w_ms_next >= c_MIN_GREEN) begin
                        w_state_next   = S_YELLOW;
                        w_pending_next = 1'b0;
                    end else begin
                        w_pending_next = 1'b1;
                    end
                end
                S_YELLOW: w_err_next = 1'b1;
                default:  ;
            endcase
        end else begin
            case (r_state)
                S_GREEN: begin
                    if (r_pending && (w_ms_next >= c_MIN_GREEN)) begin
                        w_state_next   = S_YELLOW;
                        w_pending_next = 1'b0;
                    end
                end
                S_YELLOW: begin
                    if (w_ms_next >= c_YELLOW) begin
                        w_state_next = S_RED;
                    end
                end
                default: ;
            endcase
        end
        w_restart = w_forced | (w_state_next != r_state);
    end

    always_ff @(posedge CLK) begin
        if (reset_general) begin
            r_state    <= S_RED;
            r_change_d <= 1'b0;
            r_presc    <= '0;
            r_ms       <= 16'd0;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_change_d <= change;
            r_pending  <= w_pending_next;
            r_err      <= w_err_next;
            if (w_restart) begin
                r_presc <= '0;
                r_ms    <= 16'd0;
            end else begin
                r_presc <= w_tick ? '0 : (r_presc + c_PRESC_W'(1));
                r_ms    <= w_ms_next;
            end
        end
    end

`ifdef BLINK_EN
    logic [15:0] r_blink_ms;
    logic [15:0] w_blink_ms_next;
    logic        r_blink;
    logic        w_blink_next;

    // Blink phase restarts lit on every state entry; only consumed while DARK.
    always_comb begin
        w_blink_ms_next = r_blink_ms;
        w_blink_next    = r_blink;
        if (w_restart) begin
            w_blink_ms_next = 16'd0;
            w_blink_next    = 1'b1;
        end else if (w_tick) begin
            if (r_blink_ms >= c_BLINK_LAST) begin
                w_blink_ms_next = 16'd0;
                w_blink_next    = ~r_blink;
            end else begin
                w_blink_ms_next = r_blink_ms + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset_general) begin
            r_blink_ms <= 16'd0;
            r_blink    <= 1'b1;
        end else begin
            r_blink_ms <= w_blink_ms_next;
            r_blink    <= w_blink_next;
        end
    end

    assign w_dark_yellow = w_blink_next;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^c_BLINK_LAST;
    assign w_dark_yellow  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset_general) begin
            r_lamp_red    <= 1'b1;
            r_lamp_yellow <= 1'b0;
            r_lamp_green  <= 1'b0;
            r_is_red      <= 1'b1;
        end else begin
            r_lamp_red    <= (w_state_next == S_RED);
            r_lamp_green  <= (w_state_next == S_GREEN);
            r_lamp_yellow <= (w_state_next == S_YELLOW) |
                             ((w_state_next == S_DARK) & w_dark_yellow);
            r_is_red      <= (w_state_next == S_RED);
        end
    end

    assign lamp_red    = r_lamp_red;
    assign lamp_yellow = r_lamp_yellow;
    assign lamp_green  = r_lamp_green;
    assign is_red      = r_is_red;
    assign pending     = r_pending;
    assign err_dropped = r_err;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_light_unit
// Brief   : Directed + randomized bench for traffic_light_unit against an
//           elapsed-cycle reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_traffic_light_unit;

    localparam int CPM  = 2;
    localparam int YEL  = 3;
    localparam int MING = 5;
    localparam int HALF = 2;

    localparam int M_RED = 0, M_GREEN = 1, M_YELLOW = 2, M_DARK = 3;

    logic CLK = 1'b0;
    logic reset_general = 1'b0;
    logic enable_general = 1'b0;
    logic change = 1'b0;
    logic set_req = 1'b0;
    logic set_value = 1'b0;
    logic lamp_red, lamp_yellow, lamp_green, is_red, pending, err_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_unit #(
        .CYCLES_PER_MS (CPM),
        .YELLOW_MS     (YEL),
        .MIN_GREEN_MS  (MING),
        .BLINK_HALF_MS (HALF)
    ) dut (
        .CLK            (CLK),
        .reset_general  (reset_general),
        .enable_general (enable_general),
        .change         (change),
        .set_req        (set_req),
        .set_value      (set_value),
        .lamp_red       (lamp_red),
        .lamp_yellow    (lamp_yellow),
        .lamp_green     (lamp_green),
        .is_red         (is_red),
        .pending        (pending),
        .err_dropped    (err_dropped)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference model: state plus cycles elapsed since the last state entry.
    int m_state = M_RED;
    int m_cyc   = 0;
    bit m_pend  = 0;
    bit m_err   = 0;
    bit m_chg_d = 0;
    bit m_valid = 0;

    always @(posedge CLK) begin : model_upd
        bit edge_seen;
        bit restart;
        int ns;
        int reach_ms;
        edge_seen = change && !m_chg_d;
        m_chg_d   = change;
        if (reset_general) begin
            m_valid = 1; m_state = M_RED; m_cyc = 0; m_pend = 0; m_err = 0; m_chg_d = 0;
        end else if (m_valid) begin
            ns       = m_state;
            restart  = 0;
            reach_ms = (m_cyc + 1) / CPM;
            if (reach_ms > 65535) reach_ms = 65535;
            if (!enable_general) begin
                ns = M_DARK; m_pend = 0;
            end else if (m_state == M_DARK) begin
                ns = M_RED;
            end else if (set_req) begin
                ns = set_value ? M_GREEN : M_RED; restart = 1; m_pend = 0;
            end else if (edge_seen) begin
                if (m_state == M_RED) ns = M_GREEN;
                else if (m_state == M_GREEN) begin
                    if (reach_ms >= MING) begin ns = M_YELLOW; m_pend = 0; end
                    else m_pend = 1;
                end else if (m_state == M_YELLOW) m_err = 1;
            end else if (m_state == M_GREEN && m_pend && reach_ms >= MING) begin
                ns = M_YELLOW; m_pend = 0;
            end else if (m_state == M_YELLOW && reach_ms >= YEL) begin
                ns = M_RED;
            end
            if (restart || ns != m_state) m_cyc = 0;
            else m_cyc = m_cyc + 1;
            m_state = ns;
        end
    end

    function automatic logic exp_yellow();
        if (m_state == M_YELLOW) return 1'b1;
`ifdef BLINK_EN
        if (m_state == M_DARK) return ((m_cyc / (CPM * HALF)) % 2) == 0;
`endif
        return 1'b0;
    endfunction

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cmp_lamp_red",    lamp_red,    m_state == M_RED);
            chk("cmp_lamp_green",  lamp_green,  m_state == M_GREEN);
            chk("cmp_lamp_yellow", lamp_yellow, exp_yellow());
            chk("cmp_is_red",      is_red,      m_state == M_RED);
            chk("cmp_pending",     pending,     m_pend);
            chk("cmp_err_dropped", err_dropped, m_err);
        end
    end

    initial begin : stim
        logic [7:0] blink_pat;
        int dark_left;
`ifdef BLINK_EN
        blink_pat = 8'b0000_1111;
`else
        blink_pat = 8'b0000_0000;
`endif
        dark_left = 0;

        reset_general = 1'b1;
        step(2);
        reset_general = 1'b0; enable_general = 1'b1;
        step(1);
        chk("rst_red", lamp_red, 1'b1);
        chk("rst_is_red", is_red, 1'b1);
        chk("rst_green", lamp_green, 1'b0);
        chk("rst_err", err_dropped, 1'b0);

        // 1: basic cycle with exact yellow dwell
        change = 1; step(1);
        chk("t1_green", lamp_green, 1'b1);
        chk("t1_not_red", is_red, 1'b0);
        change = 0; step(9);
        change = 1; step(1);
        chk("t1_yellow", lamp_yellow, 1'b1);
        change = 0; step(5);
        chk("t1_yellow_hold", lamp_yellow, 1'b1);
        step(1);
        chk("t1_red", lamp_red, 1'b1);
        chk("t1_is_red", is_red, 1'b1);

        // 2: early change latched as pending
        change = 1; step(1); change = 0;
        step(1); change = 1; step(1); change = 0;
        chk("t2_pending", pending, 1'b1);
        chk("t2_green_held", lamp_green, 1'b1);
        step(7);
        chk("t2_pending_hold", pending, 1'b1);
        step(1);
        chk("t2_yellow", lamp_yellow, 1'b1);
        chk("t2_pending_clr", pending, 1'b0);
        step(6);
        chk("t2_red", lamp_red, 1'b1);

        // 3: held change acts once
        change = 1; step(20);
        chk("t3_green", lamp_green, 1'b1);
        chk("t3_no_yellow", lamp_yellow, 1'b0);
        change = 0; set_req = 1; set_value = 0; step(1); set_req = 0;
        chk("t3_forced_red", lamp_red, 1'b1);

        // 4: change during yellow dropped and sticky error
        change = 1; step(1); change = 0; step(9);
        change = 1; step(1); change = 0;
        chk("t4_yellow", lamp_yellow, 1'b1);
        chk("t4_err0", err_dropped, 1'b0);
        step(1); change = 1; step(1); change = 0;
        chk("t4_still_yellow", lamp_yellow, 1'b1);
        chk("t4_err1", err_dropped, 1'b1);
        step(4);
        chk("t4_red", lamp_red, 1'b1);
        chk("t4_err_sticky", err_dropped, 1'b1);
        reset_general = 1; step(1); reset_general = 0;
        chk("t4_err_cleared", err_dropped, 1'b0);

        // 5: force strobe beats change, restarts timer
        set_req = 1; set_value = 1; change = 1; step(1);
        chk("t5_green", lamp_green, 1'b1);
        chk("t5_pending0", pending, 1'b0);
        set_req = 0; change = 0; step(8);
        set_req = 1; step(1); set_req = 0;
        change = 1; step(1); change = 0;
        chk("t5_restart_pending", pending, 1'b1);
        chk("t5_restart_green", lamp_green, 1'b1);
        set_req = 1; set_value = 0; step(1); set_req = 0;
        chk("t5_red", lamp_red, 1'b1);
        chk("t5_pending_clr", pending, 1'b0);

        // 6: dark mode
        enable_general = 0; step(1);
        chk("t6_not_red", is_red, 1'b0);
        chk("t6_red_off", lamp_red, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t6_blink", lamp_yellow, blink_pat[i]);
            step(1);
        end
        enable_general = 1; set_req = 1; set_value = 1; step(1); set_req = 0;
        chk("t6_red", lamp_red, 1'b1);
        chk("t6_is_red", is_red, 1'b1);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset_general = ($urandom_range(0, 299) == 0);
            if (dark_left > 0) begin
                enable_general = 0; dark_left--;
            end else begin
                enable_general = 1;
                if ($urandom_range(0, 199) == 0) dark_left = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 5) == 0) change = ~change;
            set_req   = ($urandom_range(0, 39) == 0);
            set_value = 1'($urandom_range(0, 1));
            step(1);
        end

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
